// File: rtl/det_rr_scheduler_if.sv
// Handshake and result bundle between parallel producers and the shared pattern-detector scheduler.
// The master side is the producer/observer and the slave side is the scheduler.
interface det_rr_scheduler_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WORD_W = 8,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned ID_W   = $clog2(NREQ)
);
  logic [NREQ-1:0]        req;
  logic [NREQ*WORD_W-1:0] data;
  logic [NREQ-1:0]        ack;
  logic                   busy;
  logic                   ser_bit;
  logic                   ser_valid;
  logic                   hit;
  logic                   done;
  logic [ID_W-1:0]        done_id;
  logic [CNT_W-1:0]       hit_count;

  modport master (
    output req, data,
    input  ack, busy, ser_bit, ser_valid, hit, done, done_id, hit_count
  );

  modport slave (
    input  req, data,
    output ack, busy, ser_bit, ser_valid, hit, done, done_id, hit_count
  );
endinterface

// File: rtl/det_rr_scheduler.sv
// Round-robin scheduler that serialises one requester's word at a time, MSB first, through a
// sliding-window pattern detector and reports the overlapping-match count tagged with the index.
module det_rr_scheduler #(
  parameter int unsigned       NREQ    = 4,
  parameter int unsigned       WORD_W  = 8,
  parameter int unsigned       PAT_W   = 4,
  parameter logic [PAT_W-1:0]  PATTERN = 4'b1011,
  parameter int unsigned       CNT_W   = 4
) (
  input logic               clk,
  input logic               rst,
  det_rr_scheduler_if.slave bus
);

  localparam int unsigned ID_W = $clog2(NREQ);
  localparam int unsigned BCW  = $clog2(WORD_W + 1);
  localparam logic [BCW-1:0] WordLast = BCW'(WORD_W - 1);
  localparam logic [BCW-1:0] PatLast  = BCW'(PAT_W - 1);

  typedef enum logic [1:0] {StIdle, StShift, StReport} state_e;

  state_e              state_q;
  logic [ID_W-1:0]     last_q;
  logic [WORD_W-1:0]   shift_q;
  logic [PAT_W-1:0]    window_q;
  logic [BCW-1:0]      bit_cnt_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [NREQ-1:0]     ack_q;
  logic                busy_q;
  logic                ser_bit_q;
  logic                ser_valid_q;
  logic                hit_q;
  logic                done_q;
  logic [ID_W-1:0]     done_id_q;
  logic [CNT_W-1:0]    hit_count_q;

  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     idx;
  logic [WORD_W-1:0]   word_sel;
  logic                cur_bit;
  logic [PAT_W-1:0]    win_next;
  logic                match;

  // Scan from last+NREQ down to last+1 so the closest set request after the pointer wins.
  always_comb begin
    winner = last_q;
    idx    = '0;
    for (int off = int'(NREQ); off >= 1; off--) begin
      idx = ID_W'((int'(last_q) + off) % int'(NREQ));
      if (bus.req[idx]) winner = idx;
    end
  end

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (ID_W'(i) == winner) word_sel = bus.data[i*WORD_W +: WORD_W];
    end
  end

  assign cur_bit  = shift_q[WORD_W-1];
  assign win_next = PAT_W'({window_q, cur_bit});
  // Ignore matches until PAT_W real bits have entered the zero-filled window.
  assign match    = (win_next == PATTERN) && (bit_cnt_q >= PatLast);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      last_q      <= ID_W'(NREQ - 1);
      shift_q     <= '0;
      window_q    <= '0;
      bit_cnt_q   <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      ser_bit_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      hit_count_q <= '0;
    end else begin
      ack_q  <= '0;
      hit_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (|bus.req) begin
            state_q        <= StShift;
            shift_q        <= word_sel;
            last_q         <= winner;
            ack_q[winner]  <= 1'b1;
            bit_cnt_q      <= '0;
            window_q       <= '0;
            cnt_q          <= '0;
            busy_q         <= 1'b1;
          end
        end
        StShift: begin
          ser_valid_q <= 1'b1;
          ser_bit_q   <= cur_bit;
          shift_q     <= shift_q << 1;
          window_q    <= win_next;
          bit_cnt_q   <= bit_cnt_q + BCW'(1);
          if (match) begin
            hit_q <= 1'b1;
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
          end
          if (bit_cnt_q == WordLast) state_q <= StReport;
        end
        StReport: begin
          ser_valid_q <= 1'b0;
          ser_bit_q   <= 1'b0;
          done_q      <= 1'b1;
          done_id_q   <= last_q;
          hit_count_q <= cnt_q;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.ser_bit   = ser_bit_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.hit       = hit_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.hit_count = hit_count_q;

endmodule
